// File: rtl/fp_wb_pkg.sv
// rtl/fp_wb_pkg.sv - shared defaults and queue entry type for the FP writeback arbiter
package fp_wb_pkg;

    localparam int FIFO_DEPTH_DEF   = 4;
    localparam int STARVE_LIMIT_DEF = 3;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } fp_wb_entry_t;

endpackage

// File: rtl/fp_wb_fifo.sv
// rtl/fp_wb_fifo.sv - FPU result queue with per-slot valid and destination outputs
// Ports: clk, rst (sync, active-high); push/push_entry enqueue at tail;
// pop dequeues head_entry; count is occupancy; entry_valid/entry_rd expose
// every slot so the parent can build its pending-register mask.
module fp_wb_fifo
    import fp_wb_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  fp_wb_entry_t       push_entry,
    input  logic               pop,
    output fp_wb_entry_t       head_entry,
    output logic [2:0]         count,
    output logic [DEPTH-1:0]   entry_valid,
    output logic [DEPTH*5-1:0] entry_rd
);

    localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    fp_wb_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Guards make the queue safe on its own even if a caller over-drives.
    assign do_push    = push && (count < DEPTH_C);
    assign do_pop     = pop && (count != 3'd0);
    assign head_entry = mem[rd_ptr];

    always_comb begin
        entry_rd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_rd[i*5 +: 5] = mem[i].rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            // Push and pop never hit the same slot: push needs a free slot,
            // pop needs an occupied one.
            if (do_push) begin
                mem[wr_ptr]         <= push_entry;
                entry_valid[wr_ptr] <= 1'b1;
                wr_ptr              <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                entry_valid[rd_ptr] <= 1'b0;
                rd_ptr              <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fp_wb_arbiter.sv
// rtl/fp_wb_arbiter.sv - arbitrates FPU queue and FLW load results onto one FP register write port
// Ports: clk, rst (sync, active-high); fpu_valid/fpu_ready/fpu_rd/fpu_data
// FPU result input; ld_valid/ld_ready/ld_rd/ld_data load result input;
// wb_enable_f/rd_temp_f_wb/wb_data_f registered write port; pending_mask
// marks registers with queued writes; fifo_count is queue occupancy.
module fp_wb_arbiter
    import fp_wb_pkg::*;
#(
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fpu_valid,
    output logic        fpu_ready,
    input  logic [4:0]  fpu_rd,
    input  logic [31:0] fpu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    output logic        wb_enable_f,
    output logic [4:0]  rd_temp_f_wb,
    output logic [31:0] wb_data_f,
    output logic [31:0] pending_mask,
    output logic [2:0]  fifo_count
);

    localparam int         SW      = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);
    localparam logic [2:0] DEPTH_C = 3'(FIFO_DEPTH);

    fp_wb_entry_t              push_entry;
    fp_wb_entry_t              head_entry;
    logic                      push;
    logic                      q_empty;
    logic                      ld_win;
    logic                      q_win;
    logic [SW-1:0]             starve_cnt;
    logic [FIFO_DEPTH-1:0]     entry_valid;
    logic [FIFO_DEPTH*5-1:0]   entry_rd;

    // Readiness uses the registered count only, so a pop in the same cycle
    // never frees space for a push.
    assign fpu_ready  = (fifo_count < DEPTH_C);
    // Writes to x0-equivalent f0 are accepted and dropped, never queued.
    assign push       = fpu_valid && fpu_ready && (fpu_rd != 5'd0);
    assign push_entry = '{rd: fpu_rd, data: fpu_data};
    assign q_empty    = (fifo_count == 3'd0);

    // Loads normally win; after STARVE_LIMIT consecutive wins over a
    // non-empty queue the head is forced through.
    assign ld_win   = ld_valid && (starve_cnt < LIMIT_C);
    assign q_win    = !q_empty && !ld_win;
    assign ld_ready = ld_win;

    fp_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (q_win),
        .head_entry  (head_entry),
        .count       (fifo_count),
        .entry_valid (entry_valid),
        .entry_rd    (entry_rd)
    );

    // OR of all live slots, so duplicate destinations stay pending until
    // the last one drains.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_valid[i]) begin
                pending_mask[entry_rd[i*5 +: 5]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (q_empty || q_win) begin
            starve_cnt <= '0;
        end else if (ld_win) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_enable_f  <= 1'b0;
            rd_temp_f_wb <= '0;
            wb_data_f    <= '0;
        end else if (ld_win) begin
            wb_enable_f <= (ld_rd != 5'd0);
            if (ld_rd != 5'd0) begin
                rd_temp_f_wb <= ld_rd;
                wb_data_f    <= ld_data;
            end
        end else if (q_win) begin
            wb_enable_f  <= 1'b1;
            rd_temp_f_wb <= head_entry.rd;
            wb_data_f    <= head_entry.data;
        end else begin
            wb_enable_f <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// tb/tb_fp_wb_arbiter.sv - directed self-checking bench for fp_wb_arbiter
module tb_fp_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        fpu_valid;
    logic        fpu_ready;
    logic [4:0]  fpu_rd;
    logic [31:0] fpu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        wb_enable_f;
    logic [4:0]  rd_temp_f_wb;
    logic [31:0] wb_data_f;
    logic [31:0] pending_mask;
    logic [2:0]  fifo_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fp_wb_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .fpu_valid    (fpu_valid),
        .fpu_ready    (fpu_ready),
        .fpu_rd       (fpu_rd),
        .fpu_data     (fpu_data),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_rd        (ld_rd),
        .ld_data      (ld_data),
        .wb_enable_f  (wb_enable_f),
        .rd_temp_f_wb (rd_temp_f_wb),
        .wb_data_f    (wb_data_f),
        .pending_mask (pending_mask),
        .fifo_count   (fifo_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wb(input string tag, input logic en, input logic [4:0] rd, input logic [31:0] data);
        chk({tag, ".en"}, 32'(wb_enable_f), 32'(en));
        if (en) begin
            chk({tag, ".rd"}, 32'(rd_temp_f_wb), 32'(rd));
            chk({tag, ".data"}, wb_data_f, data);
        end
    endtask

    task automatic idle();
        fpu_valid = 1'b0;
        fpu_rd    = '0;
        fpu_data  = '0;
        ld_valid  = 1'b0;
        ld_rd     = '0;
        ld_data   = '0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step();
        step();
        chk("rst.wb_en", 32'(wb_enable_f), 32'd0);
        chk("rst.rd", 32'(rd_temp_f_wb), 32'd0);
        chk("rst.data", wb_data_f, 32'd0);
        chk("rst.count", 32'(fifo_count), 32'd0);
        chk("rst.pending", pending_mask, 32'd0);
        chk("rst.fpu_ready", 32'(fpu_ready), 32'd1);
        rst = 1'b0;
        #1;

        // Single FPU result: push at cycle 0, written at cycle 2
        fpu_valid = 1'b1; fpu_rd = 5'd5; fpu_data = 32'h3F80_0000;
        #1;
        chk("fpu1.ready", 32'(fpu_ready), 32'd1);
        step();
        idle();
        #1;
        chk("fpu1.c1.count", 32'(fifo_count), 32'd1);
        chk("fpu1.c1.pending", pending_mask, 32'h0000_0020);
        chk("fpu1.c1.wb_en", 32'(wb_enable_f), 32'd0);
        step();
        chk_wb("fpu1.c2", 1'b1, 5'd5, 32'h3F80_0000);
        chk("fpu1.c2.pending", pending_mask, 32'd0);
        chk("fpu1.c2.count", 32'(fifo_count), 32'd0);
        step();
        chk("fpu1.c3.wb_en", 32'(wb_enable_f), 32'd0);

        // Lone load: one-cycle latency
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h4049_0FDB;
        #1;
        chk("ld1.ready", 32'(ld_ready), 32'd1);
        step();
        idle();
        chk_wb("ld1.c1", 1'b1, 5'd7, 32'h4049_0FDB);
        step();
        chk("ld1.c2.wb_en", 32'(wb_enable_f), 32'd0);

        // Five FPU results with loads held: queue fills, starvation forces head out
        for (int k = 0; k < 4; k++) begin
            fpu_valid = 1'b1; fpu_rd = 5'(k + 1); fpu_data = 32'h1000_0000 + 32'(k + 1);
            ld_valid  = 1'b1; ld_rd  = 5'(10 + k); ld_data = 32'hA000_0000 + 32'(k);
            #1;
            chk($sformatf("fill%0d.fpu_ready", k), 32'(fpu_ready), 32'd1);
            chk($sformatf("fill%0d.ld_ready", k), 32'(ld_ready), 32'd1);
            step();
            chk_wb($sformatf("fill%0d", k), 1'b1, 5'(10 + k), 32'hA000_0000 + 32'(k));
        end
        fpu_valid = 1'b1; fpu_rd = 5'd5; fpu_data = 32'h1000_0005;
        ld_valid  = 1'b1; ld_rd  = 5'd14; ld_data = 32'hA000_0004;
        #1;
        chk("full.count", 32'(fifo_count), 32'd4);
        chk("full.fpu_ready", 32'(fpu_ready), 32'd0);
        chk("full.ld_ready", 32'(ld_ready), 32'd0);
        chk("full.pending", pending_mask, 32'h0000_001E);
        step();
        chk_wb("starve.head", 1'b1, 5'd1, 32'h1000_0001);
        chk("starve.count", 32'(fifo_count), 32'd3);
        chk("after.fpu_ready", 32'(fpu_ready), 32'd1);
        chk("after.ld_ready", 32'(ld_ready), 32'd1);
        step();
        idle();
        chk_wb("after.load", 1'b1, 5'd14, 32'hA000_0004);
        chk("after.count", 32'(fifo_count), 32'd4);
        chk("after.pending", pending_mask, 32'h0000_003C);
        for (int k = 2; k <= 5; k++) begin
            step();
            chk_wb($sformatf("drain%0d", k), 1'b1, 5'(k), 32'h1000_0000 + 32'(k));
        end
        step();
        chk("drain.idle.wb_en", 32'(wb_enable_f), 32'd0);
        chk("drain.count", 32'(fifo_count), 32'd0);

        // Push and pop together at count 2, pointers wrap past slot 3
        fpu_valid = 1'b1; fpu_rd = 5'd8; fpu_data = 32'hB000_0008;
        ld_valid  = 1'b1; ld_rd  = 5'd20; ld_data = 32'hC000_0000;
        step();
        chk_wb("pp.a", 1'b1, 5'd20, 32'hC000_0000);
        fpu_rd = 5'd9; fpu_data = 32'hB000_0009;
        ld_rd  = 5'd21; ld_data = 32'hC000_0001;
        step();
        chk_wb("pp.b", 1'b1, 5'd21, 32'hC000_0001);
        chk("pp.b.count", 32'(fifo_count), 32'd2);
        ld_valid = 1'b0;
        fpu_rd = 5'd10; fpu_data = 32'hB000_000A;
        step();
        chk_wb("pp.c", 1'b1, 5'd8, 32'hB000_0008);
        chk("pp.c.count", 32'(fifo_count), 32'd2);
        fpu_rd = 5'd11; fpu_data = 32'hB000_000B;
        step();
        idle();
        chk_wb("pp.d", 1'b1, 5'd9, 32'hB000_0009);
        chk("pp.d.count", 32'(fifo_count), 32'd2);
        step();
        chk_wb("pp.e", 1'b1, 5'd10, 32'hB000_000A);
        step();
        chk_wb("pp.wrap", 1'b1, 5'd11, 32'hB000_000B);
        chk("pp.count", 32'(fifo_count), 32'd0);

        // Register 0 on both sides: accepted, discarded
        fpu_valid = 1'b1; fpu_rd = 5'd0; fpu_data = 32'hDEAD_BEEF;
        ld_valid  = 1'b1; ld_rd  = 5'd0; ld_data = 32'hCAFE_F00D;
        #1;
        chk("zero.fpu_ready", 32'(fpu_ready), 32'd1);
        chk("zero.ld_ready", 32'(ld_ready), 32'd1);
        step();
        idle();
        chk("zero.wb_en", 32'(wb_enable_f), 32'd0);
        chk("zero.count", 32'(fifo_count), 32'd0);
        step();
        chk("zero.c2.wb_en", 32'(wb_enable_f), 32'd0);

        // Reset with three queued entries
        ld_valid = 1'b1;
        fpu_valid = 1'b1; fpu_rd = 5'd3; fpu_data = 32'h0000_0003; ld_rd = 5'd22; ld_data = 32'h1;
        step();
        fpu_rd = 5'd4; fpu_data = 32'h0000_0004; ld_rd = 5'd23; ld_data = 32'h2;
        step();
        fpu_rd = 5'd6; fpu_data = 32'h0000_0006; ld_rd = 5'd24; ld_data = 32'h3;
        step();
        idle();
        chk_wb("rq.load", 1'b1, 5'd24, 32'h3);
        chk("rq.count", 32'(fifo_count), 32'd3);
        chk("rq.pending", pending_mask, 32'h0000_0058);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rq.rst.wb_en", 32'(wb_enable_f), 32'd0);
        chk("rq.rst.count", 32'(fifo_count), 32'd0);
        chk("rq.rst.pending", pending_mask, 32'd0);
        chk("rq.rst.fpu_ready", 32'(fpu_ready), 32'd1);
        chk("rq.rst.data", wb_data_f, 32'd0);
        step();
        chk("rq.post.wb_en", 32'(wb_enable_f), 32'd0);
        step();
        chk("rq.post2.wb_en", 32'(wb_enable_f), 32'd0);
        chk("rq.post2.count", 32'(fifo_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fp_wb_arbiter.md
FP_WB_ARBITER -- requirements
Module: fp_wb_arbiter

Interface
REQ-001 SHALL expose parameter FIFO_DEPTH, default 4, FPU result queue entries.
REQ-002 SHALL expose parameter STARVE_LIMIT, default 3, consecutive load wins tolerated while queue non-empty.
REQ-003 SHALL have clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have fpu_valid  in  1  FPU result offered.
REQ-006 SHALL have fpu_ready  out  1  queue can accept an FPU result.
REQ-007 SHALL have fpu_rd  in  5  FPU destination register.
REQ-008 SHALL have fpu_data  in  32  FPU result.
REQ-009 SHALL have ld_valid  in  1  FLW load result offered.
REQ-010 SHALL have ld_ready  out  1  load result accepted this cycle.
REQ-011 SHALL have ld_rd  in  5  load destination register.
REQ-012 SHALL have ld_data  in  32  load result.
REQ-013 SHALL have wb_enable_f  out  1  registered write strobe to FP register bank.
REQ-014 SHALL have rd_temp_f_wb  out  5  registered write address.
REQ-015 SHALL have wb_data_f  out  32  registered write data.
REQ-016 SHALL have pending_mask  out  32  bit r set while any queued entry targets register r.
REQ-017 SHALL have fifo_count  out  3  current queue occupancy.

Function
REQ-018 fpu_ready SHALL equal (fifo_count < FIFO_DEPTH), using the registered count only; no push while full, even in a pop cycle.
REQ-019 An FPU handshake (fpu_valid && fpu_ready) with fpu_rd != 0 SHALL push {fpu_rd, fpu_data} at the tail; with fpu_rd == 0 it SHALL be accepted and discarded.
REQ-020 Each cycle the arbiter SHALL select exactly one of: load, queue head, or nothing.
REQ-021 Load SHALL win when ld_valid=1 and starve_cnt < STARVE_LIMIT; ld_ready SHALL then be 1.
REQ-022 Queue head SHALL win when non-empty and (ld_valid=0 or starve_cnt == STARVE_LIMIT); ld_ready SHALL then be 0.
REQ-023 starve_cnt SHALL increment on each load win while queue non-empty; it SHALL clear on any queue pop or whenever queue is empty.
REQ-024 Selected source SHALL appear on wb_enable_f/rd_temp_f_wb/wb_data_f on the next rising edge; load latency 1 cycle, minimum FPU latency 2 cycles (push, then pop).
REQ-025 A load win with ld_rd == 0 SHALL assert ld_ready but drive wb_enable_f=0 next cycle.
REQ-026 With nothing selected, wb_enable_f SHALL be 0 next cycle; rd_temp_f_wb/wb_data_f SHALL hold previous values.
REQ-027 Simultaneous push and pop SHALL leave fifo_count unchanged and preserve FIFO order.
REQ-028 Read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 pending_mask SHALL be combinational from valid queue entries; duplicate rd entries SHALL keep bit set until last pops.

Reset
REQ-030 While rst=1 at an edge: queue emptied, pointers and starve_cnt zero, wb_enable_f=0, rd_temp_f_wb=0, wb_data_f=0.
REQ-031 Reset mid-operation SHALL drop all queued entries without issuing writes; fpu_ready=1 on the first cycle after rst deasserts.

Structure
REQ-032 Package fp_wb_pkg SHALL hold FIFO_DEPTH/STARVE_LIMIT defaults and the entry type {rd[4:0], data[31:0]}.
REQ-033 Queue SHALL be sub-module fp_wb_fifo (push/pop/count/entry-valid outputs); arbitration and output register stay in fp_wb_arbiter.

Verification
REQ-034 Single FPU result rd=5, data=0x3F800000 at cycle 0, no loads -> wb_enable_f=1, rd=5, data=0x3F800000 at cycle 2; pending_mask[5]=1 for cycle 1 only.
REQ-035 Load rd=7, data=0x40490FDB alone -> write rd=7 one cycle later, ld_ready=1.
REQ-036 Five back-to-back FPU results (rd 1..5), ld_valid held 1 -> fpu_ready=0 after 4 pushes; after 3 load wins head rd=1 is written and ld_ready=0 that cycle; order 1..5 preserved.
REQ-037 Push and pop in same cycle at fifo_count=2 -> count stays 2; wrap past entry 3 -> correct data returned.
REQ-038 fpu_rd=0 and ld_rd=0 offered -> both accepted, no wb_enable_f pulse, fifo_count unchanged.
REQ-039 rst pulsed with 3 queued entries -> no writes issued, fifo_count=0, pending_mask=0, wb_enable_f=0 next cycle.
